board_write_scheduler: RTL and testbench
========================================

Name: board_write_scheduler

Overview:
- Sole owner of the board_RAM port; shares it between the video read path and five sprite movers (Pac-Man and four ghosts).
- Each granted mover runs one move transaction: read the destination tile, restore the tile being vacated, draw the sprite tile.
- Arbitration is round-robin. New transactions start only during vertical blanking.
- Reports move completion, wall blocking and pellet consumption to game logic.

Parameters:
- NUM_SPR, 5, number of sprite requesters (index 0 = Pac-Man, 1..4 = blinky, pinky, inky, clyde).
- ADDR_W, 10, board address width (768 blocks, row-major, addr = y*32 + x).
- TILE_W, 4, tile code width.
- RD_LAT, 1, cycles from ram_addr presented to ram_q valid.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- vblank  in  1  high while the video driver is outside the visible area.
- video_addr  in  ADDR_W  block address requested by the pixel pipeline.
- req  in  NUM_SPR  move request per sprite; held until ack.
- old_addr  in  NUM_SPR*ADDR_W  packed current block per sprite.
- new_addr  in  NUM_SPR*ADDR_W  packed target block per sprite.
- ack  out  NUM_SPR  one-cycle completion pulse per sprite.
- blocked  out  1  pulses with ack when the target was a WALL and no write occurred.
- pellet_eaten  out  1  pulses with ack[0] when Pac-Man's target held PELLET.
- busy  out  1  high in every state except IDLE.
- ram_addr  out  ADDR_W  board_RAM address.
- ram_data  out  TILE_W  board_RAM write data.
- ram_wren  out  1  board_RAM write enable.
- ram_q  in  TILE_W  board_RAM read data.

Behaviour:
- Reset (reset==0 at a clk edge): next cycle state=IDLE; ack=0, blocked=0, pellet_eaten=0, busy=0, ram_wren=0, ram_data=0; round-robin pointer=0; under[1..4]=EMPTY.
- Reset is fully effective mid-transaction: any pending write is abandoned, ram_wren is low the cycle after reset is sampled, and no ack is issued.
- ram_addr = video_addr in IDLE and ACK; otherwise it is driven by the FSM. ram_wren is high only in WR_OLD and WR_NEW.
- States:
  - IDLE: if vblank && any eligible req, grant the first requester at or after the pointer (wrapping), latch its index and addresses, and set pointer = grant+1 mod NUM_SPR. If old==new, go to WR_NEW; otherwise go to RD. Otherwise stay in IDLE.
  - RD: ram_addr = new_addr for RD_LAT cycles, then go to CAP.
  - CAP: cap <= ram_q. If cap==WALL, go to ACK with blocked set. Else go to WR_OLD.
  - WR_OLD: ram_addr = old_addr, ram_wren = 1. ram_data = EMPTY for Pac-Man, under[g] for ghost g. Go to WR_NEW.
  - WR_NEW: ram_addr = new_addr, ram_wren = 1, ram_data = sprite tile (PAC or GHOST_BASE+g). Go to ACK.
  - ACK: ack[grant] = 1. For a ghost (not blocked, old!=new): under[g] <= cap if cap is EMPTY or PELLET, else EMPTY. pellet_eaten = (grant==0 && cap==PELLET && !blocked). Go to IDLE.
- Latency from the req-sampling IDLE edge to the ack-visible edge (ack high during the ACK cycle):
  - normal move: 4+RD_LAT cycles (5 at the default);
  - blocked move: 2+RD_LAT cycles (3 at the default);
  - old==new: 2 cycles.
- A started transaction always completes even if vblank falls.
- req[i] is ignored in the cycle ack[i] is high and in the IDLE cycle immediately after it, giving the requester time to drop or update req.
- req changes while a transaction is active do not affect the latched addresses.
- Simultaneous requests are served one per transaction in round-robin order. No requester waits more than NUM_SPR-1 transactions.

Decomposition:
- board_pkg holds:
  - tile_t (logic [3:0]);
  - EMPTY=0, PELLET=1, WALL=2, PAC=3, GHOST_BASE=4 (ghost g draws 4+g-1);
  - NUM_SPR, ADDR_W, PAC_IDX=0;
  - the FSM state enum.
- Sub-module rr_arbiter: parameterised N-way round-robin. Inputs: req, pointer, enable. Outputs: one-hot grant and encoded index.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=5'b11111 → ram_wren=0, ack=0, busy=0, ram_addr tracks video_addr.
- Pac-Man move: old=495, new=496 (PELLET), vblank=1, RD_LAT=1 → cycle+1 read 496; cycle+3 write 495←0; cycle+4 write 496←3; cycle+5 ack[0]=1 and pellet_eaten=1.
- Ghost restores pellet: blinky old=100, new=101 (PELLET) → write 100←under(EMPTY), 101←4, under[1]=PELLET. A second move 101→102 then writes 101←1.
- Wall: pinky new=131 holding WALL → zero ram_wren cycles, ack[2] and blocked high together, 3 cycles after the grant edge.
- Contention: req=5'b11111 held with vblank=1 → acks in order 0,1,2,3,4, then pointer wraps to 0. With vblank=0 → no grant and busy=0.
- Reset mid-move: reset=0 asserted during WR_OLD → no WR_NEW write, no ack, IDLE next cycle.

Source files
------------

// File: rtl/board_pkg.sv
// Shared definitions for the board write scheduler.
//   tile_t       : board tile code
//   EMPTY..GHOST : tile encodings (ghost g draws GHOST_BASE + g - 1)
//   NUM_SPR, ADDR_W, TILE_W, RD_LAT, PAC_IDX : default geometry
//   ST_*         : scheduler FSM state codes
//   sprite_tile  : tile drawn by a given sprite index
package board_pkg;

  typedef logic [3:0] tile_t;

  localparam tile_t EMPTY      = 4'd0;
  localparam tile_t PELLET     = 4'd1;
  localparam tile_t WALL       = 4'd2;
  localparam tile_t PAC        = 4'd3;
  localparam tile_t GHOST_BASE = 4'd4;

  localparam int NUM_SPR = 5;
  localparam int ADDR_W  = 10;
  localparam int TILE_W  = 4;
  localparam int RD_LAT  = 1;
  localparam int PAC_IDX = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RD     = 3'd1;
  localparam state_t ST_CAP    = 3'd2;
  localparam state_t ST_WR_OLD = 3'd3;
  localparam state_t ST_WR_NEW = 3'd4;
  localparam state_t ST_ACK    = 3'd5;

  function automatic tile_t sprite_tile(input int idx);
    if (idx == PAC_IDX) return PAC;
    return tile_t'(int'(GHOST_BASE) + idx - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter (purely combinational).
//   req     : request vector
//   pointer : highest-priority index this round (must be < N)
//   enable  : when low, no grant is produced
//   grant   : one-hot grant, all zero when nothing granted
//   index   : encoded grant index (0 when nothing granted)
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  int          k;
  logic [IW-1:0] ki;
  logic        found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    k     = 0;
    ki    = '0;
    if (enable) begin
      // scan starting at the pointer, wrapping past N-1 back to 0
      for (int off = 0; off < N; off++) begin
        k = int'(pointer) + off;
        if (k >= N) k = k - N;
        ki = IW'(k);
        if (!found && req[ki]) begin
          found     = 1'b1;
          grant[ki] = 1'b1;
          index     = ki;
        end
      end
    end
  end

endmodule

// File: rtl/board_write_scheduler.sv
// Board RAM owner: shares the single board_RAM port between the video read
// path and the sprite movers. Each granted mover gets one move transaction
// (read target tile, restore vacated tile, draw sprite tile). Transactions
// start only in vertical blanking; arbitration is round-robin.
//
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   vblank          : video is outside the visible area
//   video_addr      : pixel pipeline block address (owns the RAM when idle)
//   req             : per-sprite move request, held until ack
//   old_addr        : packed current block per sprite
//   new_addr        : packed target block per sprite
//   ack             : per-sprite one-cycle completion pulse
//   blocked         : target was a wall, nothing written (with ack)
//   pellet_eaten    : Pac-Man's target held a pellet (with ack[0])
//   busy            : a transaction is in flight
//   ram_addr/ram_data/ram_wren/ram_q : board_RAM port
//
// state  | meaning
// IDLE   | video owns the RAM; grant a requester during vblank
// RD     | present target address, wait RD_LAT cycles
// CAP    | capture target tile; wall ends the move early
// WR_OLD | restore the vacated block
// WR_NEW | draw the sprite at the target block
// ACK    | pulse ack, update the ghost's remembered tile
module board_write_scheduler #(
  parameter int NUM_SPR = board_pkg::NUM_SPR,
  parameter int ADDR_W  = board_pkg::ADDR_W,
  parameter int TILE_W  = board_pkg::TILE_W,
  parameter int RD_LAT  = board_pkg::RD_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vblank,
  input  logic [ADDR_W-1:0]         video_addr,
  input  logic [NUM_SPR-1:0]        req,
  input  logic [NUM_SPR*ADDR_W-1:0] old_addr,
  input  logic [NUM_SPR*ADDR_W-1:0] new_addr,
  output logic [NUM_SPR-1:0]        ack,
  output logic                      blocked,
  output logic                      pellet_eaten,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [TILE_W-1:0]         ram_data,
  output logic                      ram_wren,
  input  logic [TILE_W-1:0]         ram_q
);

  import board_pkg::*;

  localparam int IW = $clog2(NUM_SPR);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t             state;
  logic [IW-1:0]      cur_idx;
  logic [ADDR_W-1:0]  cur_old;
  logic [ADDR_W-1:0]  cur_new;
  tile_t              cap;
  logic               blk;
  logic [IW-1:0]      pointer;
  logic [NUM_SPR-1:0] hold_mask;
  logic [CW-1:0]      rd_cnt;
  tile_t              under [NUM_SPR];

  logic [NUM_SPR-1:0] gnt_onehot;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_valid;
  logic [ADDR_W-1:0]  gnt_old;
  logic [ADDR_W-1:0]  gnt_new;
  logic [NUM_SPR-1:0] cur_onehot;
  logic               cur_is_pac;

  // The requester just acked is masked for one IDLE cycle so it can drop
  // or update its request before being considered again.
  rr_arbiter #(
    .N  (NUM_SPR),
    .IW (IW)
  ) u_arb (
    .req     (req & ~hold_mask),
    .pointer (pointer),
    .enable  ((state == ST_IDLE) && vblank),
    .grant   (gnt_onehot),
    .index   (gnt_idx)
  );

  assign gnt_valid  = |gnt_onehot;
  assign gnt_old    = old_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign gnt_new    = new_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign cur_onehot = NUM_SPR'(1) << cur_idx;
  assign cur_is_pac = (cur_idx == IW'(PAC_IDX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cur_idx   <= '0;
      cur_old   <= '0;
      cur_new   <= '0;
      cap       <= EMPTY;
      blk       <= 1'b0;
      pointer   <= '0;
      hold_mask <= '0;
      rd_cnt    <= '0;
      for (int i = 0; i < NUM_SPR; i++) under[i] <= EMPTY;
    end else begin
      hold_mask <= (state == ST_ACK) ? cur_onehot : '0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            cur_idx <= gnt_idx;
            cur_old <= gnt_old;
            cur_new <= gnt_new;
            // cleared so an in-place move never reports a stale pellet
            cap     <= EMPTY;
            blk     <= 1'b0;
            rd_cnt  <= CW'(RD_LAT - 1);
            pointer <= (gnt_idx == IW'(NUM_SPR - 1)) ? '0 : gnt_idx + IW'(1);
            state   <= (gnt_old == gnt_new) ? ST_WR_NEW : ST_RD;
          end
        end
        ST_RD: begin
          if (rd_cnt == '0) state <= ST_CAP;
          else rd_cnt <= rd_cnt - CW'(1);
        end
        ST_CAP: begin
          cap <= ram_q;
          if (ram_q == WALL) begin
            blk   <= 1'b1;
            state <= ST_ACK;
          end else begin
            state <= ST_WR_OLD;
          end
        end
        ST_WR_OLD: state <= ST_WR_NEW;
        ST_WR_NEW: state <= ST_ACK;
        ST_ACK: begin
          // ghosts remember only restorable tiles; anything else (another
          // sprite) would leave a ghost image behind, so it becomes EMPTY
          if (!cur_is_pac && !blk && (cur_old != cur_new))
            under[cur_idx] <= ((cap == EMPTY) || (cap == PELLET)) ? cap : EMPTY;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ack          = '0;
    blocked      = 1'b0;
    pellet_eaten = 1'b0;
    busy         = (state != ST_IDLE);
    ram_addr     = video_addr;
    ram_data     = '0;
    ram_wren     = 1'b0;
    case (state)
      ST_RD, ST_CAP: ram_addr = cur_new;
      ST_WR_OLD: begin
        ram_addr = cur_old;
        ram_wren = 1'b1;
        ram_data = cur_is_pac ? EMPTY : under[cur_idx];
      end
      ST_WR_NEW: begin
        ram_addr = cur_new;
        ram_wren = 1'b1;
        ram_data = sprite_tile(int'(cur_idx));
      end
      ST_ACK: begin
        ack          = cur_onehot;
        blocked      = blk;
        pellet_eaten = cur_is_pac && (cap == PELLET) && !blk;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_board_write_scheduler.sv
module tb_board_write_scheduler;

  localparam int N     = 5;
  localparam int AW    = 10;
  localparam int TW    = 4;
  localparam int DEPTH = 768;

  localparam int T_EMPTY  = 0;
  localparam int T_PELLET = 1;
  localparam int T_WALL   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              vblank = 1'b0;
  logic [AW-1:0]     video_addr = '0;
  logic [N-1:0]      req = '0;
  logic [N*AW-1:0]   old_addr = '0;
  logic [N*AW-1:0]   new_addr = '0;
  logic [N-1:0]      ack;
  logic              blocked;
  logic              pellet_eaten;
  logic              busy;
  logic [AW-1:0]     ram_addr;
  logic [TW-1:0]     ram_data;
  logic              ram_wren;
  logic [TW-1:0]     ram_q = '0;

  always #5 clk = ~clk;

  board_write_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .vblank       (vblank),
    .video_addr   (video_addr),
    .req          (req),
    .old_addr     (old_addr),
    .new_addr     (new_addr),
    .ack          (ack),
    .blocked      (blocked),
    .pellet_eaten (pellet_eaten),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q)
  );

  // board RAM with one-cycle read latency, plus a preload port
  logic [TW-1:0] mem [DEPTH];
  logic          init_we = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [TW-1:0] init_data = '0;

  always @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
    else if (ram_wren && int'(ram_addr) < DEPTH) mem[ram_addr] <= ram_data;
    if (int'(ram_addr) < DEPTH) ram_q <= mem[ram_addr];
    else ram_q <= '0;
  end

  // write log observed on the RAM port, encoded addr*16 + data
  int wlog [$];
  always @(negedge clk) begin
    if (ram_wren) wlog.push_back(int'(ram_addr) * 16 + int'(ram_data));
  end

  // reference model
  int board [DEPTH];
  int under_m [N];
  int exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int stile(input int g);
    return (g == 0) ? 3 : 3 + g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) under_m[i] = T_EMPTY;
  endtask

  // expected effects of one move by sprite g from o to n
  task automatic model_move(input int g, input int o, input int n,
                            output int lat, output int blk, output int pel);
    int t;
    int restore;
    exp_q.delete();
    blk = 0;
    pel = 0;
    if (o == n) begin
      exp_q.push_back(n * 16 + stile(g));
      board[n] = stile(g);
      lat = 2;
    end else begin
      t = board[n];
      if (t == T_WALL) begin
        blk = 1;
        lat = 2 + 1;
      end else begin
        restore = (g == 0) ? T_EMPTY : under_m[g];
        exp_q.push_back(o * 16 + restore);
        exp_q.push_back(n * 16 + stile(g));
        board[o] = restore;
        board[n] = stile(g);
        lat = 4 + 1;
        pel = (g == 0 && t == T_PELLET) ? 1 : 0;
        if (g != 0) under_m[g] = (t == T_EMPTY || t == T_PELLET) ? t : T_EMPTY;
      end
    end
  endtask

  task automatic set_addrs(input int g, input int o, input int n);
    old_addr[g*AW +: AW] = AW'(o);
    new_addr[g*AW +: AW] = AW'(n);
  endtask

  // single-requester move, started from a settled IDLE
  task automatic do_move(input int g, input int o, input int n, input string tag);
    int lat_e, blk_e, pel_e, k;
    bit seen;
    repeat (2) @(negedge clk);
    set_addrs(g, o, n);
    model_move(g, o, n, lat_e, blk_e, pel_e);
    wlog.delete();
    vblank = 1'b1;
    req = '0;
    req[g] = 1'b1;
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check({tag, "_busy"}, int'(busy), 1);
        if (o != n) check({tag, "_rdaddr"}, int'(ram_addr), n);
      end
      if (ack != '0) seen = 1;
    end
    check({tag, "_lat"}, k, lat_e);
    check({tag, "_ack"}, int'(ack), 1 << g);
    check({tag, "_blocked"}, int'(blocked), blk_e);
    check({tag, "_pellet"}, int'(pellet_eaten), pel_e);
    req = '0;
    check({tag, "_nwr"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wlog[i], exp_q[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, o, n, g, k, nack, nbusy, bad, lat_e, blk_e, pel_e;
    int order [$];

    // board contents
    for (int a = 0; a < DEPTH; a++) begin
      t = $urandom_range(0, 9);
      if (t < 4) board[a] = T_EMPTY;
      else if (t < 7) board[a] = T_PELLET;
      else if (t < 9) board[a] = T_WALL;
      else board[a] = $urandom_range(3, 7);
    end
    board[495] = T_EMPTY;  board[496] = T_PELLET;
    board[100] = T_EMPTY;  board[101] = T_PELLET; board[102] = T_EMPTY;
    board[130] = T_EMPTY;  board[131] = T_WALL;
    model_reset();

    // reset held while preloading the RAM, all sprites requesting
    reset = 1'b0;
    vblank = 1'b1;
    req = 5'b11111;
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) begin
      init_we = 1'b1;
      init_addr = AW'(a);
      init_data = TW'(board[a]);
      @(negedge clk);
    end
    init_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      video_addr = AW'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
      check($sformatf("rst%0d_wren", c), int'(ram_wren), 0);
      check($sformatf("rst%0d_ack", c), int'(ack), 0);
      check($sformatf("rst%0d_busy", c), int'(busy), 0);
      check($sformatf("rst%0d_vaddr", c), int'(ram_addr), int'(video_addr));
    end
    req = '0;
    reset = 1'b1;
    @(negedge clk);
    video_addr = AW'(321);
    @(negedge clk);
    check("idle_vaddr", int'(ram_addr), 321);

    // directed moves
    do_move(0, 495, 496, "pac");
    do_move(1, 100, 101, "blinky1");
    do_move(1, 101, 102, "blinky2");
    do_move(2, 130, 131, "wall");
    do_move(3, 300, 300, "inplace");

    // random moves against the model
    for (int i = 0; i < 40; i++) begin
      g = $urandom_range(0, N - 1);
      o = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 5))
        0: n = o;
        1: n = o + 1;
        2: n = o - 1;
        3: n = o + 32;
        4: n = o - 32;
        default: n = $urandom_range(0, DEPTH - 1);
      endcase
      if (n < 0 || n >= DEPTH) n = o;
      video_addr = AW'($urandom_range(0, DEPTH - 1));
      do_move(g, o, n, $sformatf("rnd%0d", i));
    end

    // contention: all requesting, in-place moves, pointer starts at 0
    pulse_reset();
    for (int s = 0; s < N; s++) set_addrs(s, 200 + s, 200 + s);
    vblank = 1'b1;
    req = 5'b11111;
    order.delete();
    k = 0;
    while (order.size() < 6 && k < 60) begin
      @(negedge clk);
      k++;
      if (ack != '0) begin
        for (int s = 0; s < N; s++) if (ack[s]) order.push_back(s);
        if (order.size() == 6) req = '0;
      end
    end
    check("rr_count", order.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : -1, i % N);
      model_move(i % N, 200 + (i % N), 200 + (i % N), lat_e, blk_e, pel_e);
    end

    // no grants outside vblank, then pointer resumes at 1
    @(negedge clk);
    vblank = 1'b0;
    req = 5'b00110;
    nack = 0;
    nbusy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack != '0) nack++;
      if (busy) nbusy++;
    end
    check("novb_ack", nack, 0);
    check("novb_busy", nbusy, 0);
    vblank = 1'b1;
    k = 0;
    while (ack == '0 && k < 10) begin @(negedge clk); k++; end
    check("vb_first", int'(ack), 5'b00010);
    model_move(1, 201, 201, lat_e, blk_e, pel_e);
    req = 5'b00100;
    @(negedge clk);
    k = 0;
    while (ack == '0 && k < 10) begin @(negedge clk); k++; end
    check("vb_second", int'(ack), 5'b00100);
    model_move(2, 202, 202, lat_e, blk_e, pel_e);
    req = '0;

    // reset during WR_OLD
    repeat (2) @(negedge clk);
    o = 600;
    n = 601;
    while (board[n] == T_WALL) n++;
    set_addrs(0, o, n);
    req = 5'b00001;
    repeat (3) @(negedge clk);
    check("mid_pre_wren", int'(ram_wren), 1);
    check("mid_pre_addr", int'(ram_addr), o);
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    board[o] = T_EMPTY;
    model_reset();
    check("mid_wren", int'(ram_wren), 0);
    check("mid_ack", int'(ack), 0);
    check("mid_busy", int'(busy), 0);
    reset = 1'b1;
    nack = 0;
    nbusy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != '0) nack++;
      if (ram_wren) nbusy++;
    end
    check("mid_after_ack", nack, 0);
    check("mid_after_wren", nbusy, 0);

    // final board contents
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (int'(mem[a]) != board[a]) bad++;
    check("board_final", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
